// File: rtl/mrr_decoded_stream_arbiter.sv
// Packet-level round-robin merge of the decoded pathway streams, with a stall watchdog.
// Define MRR_ARB_PATHWAY_HDR_EN to prefix every packet with a pathway header word.
module mrr_decoded_stream_arbiter #(
  parameter int NUM_PATHWAYS  = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int IDX_WIDTH     = 4,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_WIDTH*NUM_PATHWAYS-1:0] i_tdata,
  input  logic [NUM_PATHWAYS-1:0]            i_tvalid,
  input  logic [NUM_PATHWAYS-1:0]            i_tlast,
  output logic [NUM_PATHWAYS-1:0]            i_tready,
  output logic [DATA_WIDTH-1:0]              o_tdata,
  output logic                               o_tvalid,
  output logic                               o_tlast,
  output logic [IDX_WIDTH-1:0]               o_tuser,
  input  logic                               o_tready,
  input  logic [TIMEOUT_WIDTH-1:0]           timeout_cycles,
  output logic [31:0]                        pkt_count,
  output logic [15:0]                        abort_count
);

  // state | meaning
  // IDLE  | pick next pathway round-robin starting at rr_ptr
  // HDR   | emit header word for the granted pathway (header build only)
  // XFER  | forward granted pathway words until tlast
  // ABORT | emit abort word after watchdog expiry
  typedef enum logic [1:0] {IDLE, XFER, ABORT, HDR} state_t;

  state_t                   state_q, state_d;
  logic [IDX_WIDTH-1:0]     rr_ptr_q, rr_ptr_d, grant_q, grant_d;
  logic [TIMEOUT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [31:0]              pkt_count_q, pkt_count_d;
  logic [15:0]              abort_count_q, abort_count_d;
  logic [DATA_WIDTH-1:0]    o_tdata_q, o_tdata_d;
  logic                     o_tvalid_q, o_tvalid_d, o_tlast_q, o_tlast_d;
  logic [IDX_WIDTH-1:0]     o_tuser_q, o_tuser_d;

  logic                              out_free, cur_valid, cur_last, pick_found;
  logic [NUM_PATHWAYS-1:0]           grant_oh, rot_valid;
  logic [2*NUM_PATHWAYS-1:0]         dbl_valid;
  logic [DATA_WIDTH*NUM_PATHWAYS-1:0] data_shift;
  logic [DATA_WIDTH-1:0]             cur_data, abort_word;
  logic [IDX_WIDTH-1:0]              pick_off, pick_idx, grant_next;
  logic [IDX_WIDTH:0]                pick_sum;

  assign out_free   = !o_tvalid_q | o_tready;
  assign grant_oh   = NUM_PATHWAYS'(1) << grant_q;
  assign cur_valid  = |(i_tvalid & grant_oh);
  assign cur_last   = |(i_tlast & grant_oh);
  assign data_shift = i_tdata >> (32'(grant_q) * DATA_WIDTH);
  assign cur_data   = data_shift[DATA_WIDTH-1:0];
  assign abort_word = DATA_WIDTH'({16'hDEAD, {(16-IDX_WIDTH){1'b0}}, grant_q});
  assign grant_next = (grant_q == IDX_WIDTH'(NUM_PATHWAYS-1)) ? '0 : grant_q + IDX_WIDTH'(1);

  // Rotate valids so bit 0 is rr_ptr; the lowest set bit is the round-robin winner.
  assign dbl_valid = {i_tvalid, i_tvalid} >> rr_ptr_q;
  assign rot_valid = dbl_valid[NUM_PATHWAYS-1:0];

  always_comb begin
    pick_found = 1'b0;
    pick_off   = '0;
    for (int i = NUM_PATHWAYS-1; i >= 0; i--) begin
      if (rot_valid[i]) begin
        pick_found = 1'b1;
        pick_off   = IDX_WIDTH'(i);
      end
    end
  end

  assign pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
  assign pick_idx = (pick_sum >= (IDX_WIDTH+1)'(NUM_PATHWAYS))
                    ? IDX_WIDTH'(pick_sum - (IDX_WIDTH+1)'(NUM_PATHWAYS))
                    : pick_sum[IDX_WIDTH-1:0];

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    stall_cnt_d   = stall_cnt_q;
    pkt_count_d   = pkt_count_q;
    abort_count_d = abort_count_q;
    o_tdata_d     = o_tdata_q;
    o_tlast_d     = o_tlast_q;
    o_tuser_d     = o_tuser_q;
    o_tvalid_d    = o_tvalid_q & ~o_tready;
    i_tready      = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
`ifdef MRR_ARB_PATHWAY_HDR_EN
          state_d = HDR;
`else
          state_d = XFER;
`endif
        end
      end
`ifdef MRR_ARB_PATHWAY_HDR_EN
      HDR: begin
        if (out_free) begin
          o_tvalid_d = 1'b1;
          o_tdata_d  = DATA_WIDTH'({8'hA5, 8'(grant_q), pkt_count_q[15:0]});
          o_tlast_d  = 1'b0;
          o_tuser_d  = grant_q;
          state_d    = XFER;
        end
      end
`endif
      XFER: begin
        i_tready = grant_oh & {NUM_PATHWAYS{out_free}};
        if (cur_valid && out_free) begin
          o_tvalid_d  = 1'b1;
          o_tdata_d   = cur_data;
          o_tlast_d   = cur_last;
          o_tuser_d   = grant_q;
          stall_cnt_d = '0;
          if (cur_last) begin
            state_d     = IDLE;
            rr_ptr_d    = grant_next;
            pkt_count_d = pkt_count_q + 32'd1;
          end
        end else if (!cur_valid) begin
          // Only a silent source counts as stalled; downstream backpressure does not.
          if (timeout_cycles != '0 && stall_cnt_q == timeout_cycles - TIMEOUT_WIDTH'(1)) begin
            state_d     = ABORT;
            stall_cnt_d = '0;
          end else begin
            stall_cnt_d = stall_cnt_q + TIMEOUT_WIDTH'(1);
          end
        end
      end
      ABORT: begin
        if (out_free) begin
          o_tvalid_d    = 1'b1;
          o_tdata_d     = abort_word;
          o_tlast_d     = 1'b1;
          o_tuser_d     = grant_q;
          abort_count_d = (abort_count_q == 16'hFFFF) ? abort_count_q : abort_count_q + 16'd1;
          rr_ptr_d      = grant_next;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      stall_cnt_q   <= '0;
      pkt_count_q   <= '0;
      abort_count_q <= '0;
      o_tdata_q     <= '0;
      o_tvalid_q    <= 1'b0;
      o_tlast_q     <= 1'b0;
      o_tuser_q     <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      stall_cnt_q   <= stall_cnt_d;
      pkt_count_q   <= pkt_count_d;
      abort_count_q <= abort_count_d;
      o_tdata_q     <= o_tdata_d;
      o_tvalid_q    <= o_tvalid_d;
      o_tlast_q     <= o_tlast_d;
      o_tuser_q     <= o_tuser_d;
    end
  end

  assign o_tdata     = o_tdata_q;
  assign o_tvalid    = o_tvalid_q;
  assign o_tlast     = o_tlast_q;
  assign o_tuser     = o_tuser_q;
  assign pkt_count   = pkt_count_q;
  assign abort_count = abort_count_q;

endmodule

// File: tb/tb_mrr_decoded_stream_arbiter.sv
// Directed bench for mrr_decoded_stream_arbiter (default build, header word disabled).
module tb_mrr_decoded_stream_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int TW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW*N-1:0] i_tdata;
  logic [N-1:0]    i_tvalid, i_tlast, i_tready;
  logic [DW-1:0]   o_tdata;
  logic            o_tvalid, o_tlast, o_tready;
  logic [IW-1:0]   o_tuser;
  logic [TW-1:0]   timeout_cycles;
  logic [31:0]     pkt_count;
  logic [15:0]     abort_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Per-pathway source FIFOs: {tlast, tdata}
  logic [DW:0]   smem [N][32];
  int            shead [N];
  int            stail [N];
  logic [DW-1:0] cap_data [$];
  logic [IW-1:0] cap_user [$];
  logic          cap_last [$];
  int            cap_cyc  [$];

  always #5 clk = ~clk;

  mrr_decoded_stream_arbiter #(
    .NUM_PATHWAYS(N), .DATA_WIDTH(DW), .IDX_WIDTH(IW), .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tlast(i_tlast), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tlast(o_tlast), .o_tuser(o_tuser),
    .o_tready(o_tready), .timeout_cycles(timeout_cycles),
    .pkt_count(pkt_count), .abort_count(abort_count)
  );

  task automatic present();
    for (int p = 0; p < N; p++) begin
      if (shead[p] < stail[p]) begin
        i_tvalid[p]        = 1'b1;
        i_tlast[p]         = smem[p][shead[p]][DW];
        i_tdata[DW*p +: DW] = smem[p][shead[p]][DW-1:0];
      end else begin
        i_tvalid[p]        = 1'b0;
        i_tlast[p]         = 1'b0;
        i_tdata[DW*p +: DW] = '0;
      end
    end
  endtask

  task automatic push(input int p, input logic [DW-1:0] d, input logic l);
    smem[p][stail[p]] = {l, d};
    stail[p]++;
    present();
  endtask

  // Source pops and output capture; handshakes sampled at negedge, sources advance after posedge.
  initial begin
    logic [N-1:0] hs;
    forever begin
      @(negedge clk);
      hs = i_tvalid & i_tready;
      if (o_tvalid && o_tready) begin
        cap_data.push_back(o_tdata);
        cap_user.push_back(o_tuser);
        cap_last.push_back(o_tlast);
        cap_cyc.push_back(cyc);
      end
      @(posedge clk);
      cyc++;
      #1;
      for (int p = 0; p < N; p++) if (hs[p]) shead[p]++;
      present();
    end
  end

  task automatic clear_caps();
    cap_data.delete();
    cap_user.delete();
    cap_last.delete();
    cap_cyc.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b0;
    for (int p = 0; p < N; p++) begin shead[p] = 0; stail[p] = 0; end
    present();
    o_tready = 1'b1;
    timeout_cycles = '0;
    @(posedge clk); #2;
    rst = 1'b1;
    clear_caps();
  endtask

  task automatic wait_caps(input int n, input int maxc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      @(posedge clk); #2;
      if (cap_data.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL reset_o_tvalid got %0b want 0", o_tvalid); end
    checks++; if (o_tlast !== 1'b0) begin errors++; $display("FAIL reset_o_tlast got %0b want 0", o_tlast); end
    checks++; if (o_tdata !== '0) begin errors++; $display("FAIL reset_o_tdata got %h want 0", o_tdata); end
    checks++; if (o_tuser !== '0) begin errors++; $display("FAIL reset_o_tuser got %0d want 0", o_tuser); end
    checks++; if (i_tready !== '0) begin errors++; $display("FAIL reset_i_tready got %b want 0", i_tready); end
    checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL reset_pkt_count got %0d want 0", pkt_count); end
    checks++; if (abort_count !== 16'd0) begin errors++; $display("FAIL reset_abort_count got %0d want 0", abort_count); end
  endtask

  task automatic test_single_packet();
    logic [DW-1:0] exp_d [3];
    int c0;
    bit ok;
    exp_d = '{32'h11, 32'h22, 32'h33};
    do_reset();
    c0 = cyc;
    push(2, 32'h11, 1'b0);
    push(2, 32'h22, 1'b0);
    push(2, 32'h33, 1'b1);
    wait_caps(3, 20, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL single_timeout got %0d beats want 3", cap_data.size());
    end else begin
      checks++; if (cap_cyc[0] !== c0 + 2) begin errors++; $display("FAIL single_latency got cycle %0d want %0d", cap_cyc[0], c0 + 2); end
      checks++; if (cap_cyc[2] - cap_cyc[0] !== 2) begin errors++; $display("FAIL single_consecutive got span %0d want 2", cap_cyc[2] - cap_cyc[0]); end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({cap_user[i], cap_last[i], cap_data[i]} !== {IW'(2), (i == 2), exp_d[i]}) begin
          errors++; $display("FAIL single_beat%0d got user=%0d last=%0b data=%h want user=2 last=%0b data=%h",
                             i, cap_user[i], cap_last[i], cap_data[i], (i == 2), exp_d[i]);
        end
      end
      checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL single_pkt_count got %0d want 1", pkt_count); end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int p, j, w;
    do_reset();
    for (int jj = 0; jj < 2; jj++)
      for (int pp = 0; pp < N; pp++)
        for (int ww = 0; ww < 2; ww++) push(pp, DW'(pp*256 + jj*16 + ww), ww == 1);
    wait_caps(16, 100, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rr_timeout got %0d beats want 16", cap_data.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        j = i / 8; p = (i / 2) % N; w = i % 2;
        checks++;
        if ({cap_user[i], cap_last[i], cap_data[i]} !== {IW'(p), (w == 1), DW'(p*256 + j*16 + w)}) begin
          errors++; $display("FAIL rr_beat%0d got user=%0d last=%0b data=%h want user=%0d last=%0b data=%h",
                             i, cap_user[i], cap_last[i], cap_data[i], p, (w == 1), DW'(p*256 + j*16 + w));
        end
      end
      checks++; if (pkt_count !== 32'd8) begin errors++; $display("FAIL rr_pkt_count got %0d want 8", pkt_count); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    push(0, 32'hA0, 1'b0);
    push(0, 32'hA1, 1'b1);
    push(0, 32'hB0, 1'b0);
    push(0, 32'hB1, 1'b1);
    wait_caps(4, 30, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b2b_timeout got %0d beats want 4", cap_data.size());
    end else begin
      checks++; if (cap_cyc[1] - cap_cyc[0] !== 1) begin errors++; $display("FAIL b2b_intra_gap got %0d want 1", cap_cyc[1] - cap_cyc[0]); end
      checks++; if (cap_cyc[2] - cap_cyc[1] !== 2) begin errors++; $display("FAIL b2b_inter_gap got %0d want 2", cap_cyc[2] - cap_cyc[1]); end
      checks++; if (cap_data[2] !== 32'hB0 || cap_last[1] !== 1'b1) begin errors++; $display("FAIL b2b_data got %h/%0b want b0/1", cap_data[2], cap_last[1]); end
      checks++; if (pkt_count !== 32'd2) begin errors++; $display("FAIL b2b_pkt_count got %0d want 2", pkt_count); end
    end
  endtask

  task automatic test_backpressure();
    bit pat [12];
    bit prev_stall;
    logic [DW-1:0] prev_data;
    pat = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    do_reset();
    for (int w = 0; w < 4; w++) push(0, DW'(32'h100 + w), w == 3);
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #2;
      o_tready = pat[k];
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (o_tvalid !== 1'b1 || o_tdata !== prev_data) begin
          errors++; $display("FAIL bp_hold k=%0d got valid=%0b data=%h want valid=1 data=%h", k, o_tvalid, o_tdata, prev_data);
        end
      end
      if (o_tvalid && !o_tready) begin
        checks++;
        if (i_tready !== '0) begin errors++; $display("FAIL bp_tready k=%0d got %b want 0", k, i_tready); end
      end
      prev_stall = o_tvalid && !o_tready;
      prev_data  = o_tdata;
    end
    o_tready = 1'b1;
    checks++;
    if (cap_data.size() !== 4) begin
      errors++; $display("FAIL bp_count got %0d beats want 4", cap_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cap_data[i] !== DW'(32'h100 + i)) begin errors++; $display("FAIL bp_beat%0d got %h want %h", i, cap_data[i], DW'(32'h100 + i)); end
      end
    end
  endtask

  task automatic test_watchdog();
    bit ok;
    do_reset();
    timeout_cycles = 16'd5;
    push(1, 32'h111, 1'b0);
    push(3, 32'h333, 1'b1);
    wait_caps(3, 40, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL wd_timeout got %0d beats want 3", cap_data.size());
    end else begin
      checks++; if ({cap_user[0], cap_last[0], cap_data[0]} !== {IW'(1), 1'b0, 32'h111}) begin errors++; $display("FAIL wd_first got user=%0d last=%0b data=%h want 1/0/111", cap_user[0], cap_last[0], cap_data[0]); end
      checks++; if ({cap_user[1], cap_last[1], cap_data[1]} !== {IW'(1), 1'b1, 32'hDEAD0001}) begin errors++; $display("FAIL wd_abort_word got user=%0d last=%0b data=%h want 1/1/dead0001", cap_user[1], cap_last[1], cap_data[1]); end
      checks++; if (cap_cyc[1] - cap_cyc[0] !== 6) begin errors++; $display("FAIL wd_abort_delay got %0d want 6", cap_cyc[1] - cap_cyc[0]); end
      checks++; if ({cap_user[2], cap_last[2], cap_data[2]} !== {IW'(3), 1'b1, 32'h333}) begin errors++; $display("FAIL wd_next got user=%0d last=%0b data=%h want 3/1/333", cap_user[2], cap_last[2], cap_data[2]); end
      checks++; if (abort_count !== 16'd1) begin errors++; $display("FAIL wd_abort_count got %0d want 1", abort_count); end
      checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL wd_pkt_count got %0d want 1", pkt_count); end
    end
  endtask

  task automatic test_watchdog_disabled();
    bit ok;
    do_reset();
    push(0, 32'h55, 1'b0);
    wait_caps(1, 10, ok);
    repeat (20) @(posedge clk);
    #2;
    checks++; if (abort_count !== 16'd0) begin errors++; $display("FAIL wdoff_abort_count got %0d want 0", abort_count); end
    checks++; if (cap_data.size() !== 1 || o_tvalid !== 1'b0) begin errors++; $display("FAIL wdoff_quiet got %0d beats valid=%0b want 1 beat valid=0", cap_data.size(), o_tvalid); end
    push(0, 32'h66, 1'b1);
    wait_caps(2, 10, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL wdoff_resume got %0d beats want 2", cap_data.size());
    end else begin
      checks++; if ({cap_user[1], cap_last[1], cap_data[1]} !== {IW'(0), 1'b1, 32'h66}) begin errors++; $display("FAIL wdoff_tail got user=%0d last=%0b data=%h want 0/1/66", cap_user[1], cap_last[1], cap_data[1]); end
      checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL wdoff_pkt_count got %0d want 1", pkt_count); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    for (int w = 0; w < 4; w++) push(2, DW'(32'h200 + w), w == 3);
    wait_caps(2, 20, ok);
    rst = 1'b0;
    push(0, 32'h0A, 1'b1);
    #1;
    checks++;
    if ({o_tvalid, o_tlast, o_tdata, o_tuser, i_tready, pkt_count, abort_count} !== '0) begin
      errors++; $display("FAIL rstmid_clear got valid=%0b last=%0b data=%h user=%0d tready=%b pkt=%0d abort=%0d want all 0",
                         o_tvalid, o_tlast, o_tdata, o_tuser, i_tready, pkt_count, abort_count);
    end
    @(posedge clk); #2;
    rst = 1'b1;
    clear_caps();
    wait_caps(1, 20, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rstmid_timeout got %0d beats want 1", cap_data.size());
    end else begin
      checks++; if ({cap_user[0], cap_data[0]} !== {IW'(0), 32'h0A}) begin errors++; $display("FAIL rstmid_next got user=%0d data=%h want 0/0a", cap_user[0], cap_data[0]); end
    end
  endtask

  initial begin
    rst = 1'b0;
    i_tdata = '0;
    i_tvalid = '0;
    i_tlast = '0;
    o_tready = 1'b1;
    timeout_cycles = '0;
    for (int p = 0; p < N; p++) begin shead[p] = 0; stail[p] = 0; end
    test_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    test_single_packet();
    test_round_robin();
    test_back_to_back();
    test_backpressure();
    test_watchdog();
    test_watchdog_disabled();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no completion want finish");
    $fatal(1, "global time limit");
  end

endmodule
